mult4_datapath: RTL
===================

Name: mult4_datapath

Overview:
Shift-add datapath for the 4x4 unsigned multiplier. It sits directly downstream of the 3-bit sequencer and consumes the state code v[2:0] as its only control. The sequencer runs 000 (idle) -> 001 (load) -> 010, 011, 100, 101 (four shift-add steps) -> 110 (done) -> 000. The block registers the operands, runs one partial-product step per state, and publishes a registered 8-bit product with a one-cycle done pulse. It also flags illegal or out-of-order state codes.

Parameters:
WIDTH, 4, operand width. 4 is the only legal value, because the sequencer supplies exactly four step states. Elaboration must fail for any other value.

Ports:
clk  input  1  system clock; all state changes on the rising edge
clr  input  1  reset, synchronous and active-high
v  input  3  sequencer state code
a_in  input  WIDTH  multiplicand; sampled only while v==001
b_in  input  WIDTH  multiplier; sampled only while v==001
product  output  2*WIDTH  registered result; holds until the next done
done  output  1  registered one-cycle pulse; product is valid from this cycle on
busy  output  1  registered; high while a multiplication is in flight
err  output  1  registered sticky sequencing-error flag

Behaviour:
- Internal registers:
  - A[3:0]: multiplicand.
  - P[3:0]: accumulator high half.
  - Q[3:0]: multiplier, which becomes the low half of the product.
  - prev[2:0]: the code sampled at the previous edge.
- clr=1 at an edge: A, P, Q, product, done, busy and err all become 0, and prev becomes 000. clr has priority over every other action, including mid-operation. No partial product is ever published after clr.
- Action at each edge, decoded from the current v:
  - 000 idle: hold A, P, Q and product. busy<=0.
  - 001 load: A<=a_in, Q<=b_in, P<=0, busy<=1.
  - 010 / 011 / 100 / 101 step:
    - sum[4:0] = {0,P} + (Q[0] ? {0,A} : 0).
    - Then P<=sum[4:1] and Q<={sum[0],Q[3:1]}.
    - busy<=1.
  - 110 done: product<={P,Q}, done<=1, busy<=0.
  - 111 illegal: err<=1. Hold A, P, Q and product. busy<=0.
- done is 0 at every edge where v!=110. It is therefore a single-cycle pulse under normal sequencing. If v is held at 110, done stays high and product re-latches the same value.
- Legal transitions of prev->v: 000->000, 000->001, 001->010, 010->011, 011->100, 100->101, 101->110, 110->000.
  - Any other pair sets err<=1 at that edge. The datapath still performs the action for the current v.
  - err stays set until clr.
- Latency: with v==001 at edge N, steps run at edges N+1..N+4, and done and product update at edge N+5. Under normal sequencing, done is visible 6 edges after the sequencer leaves idle.
- a_in and b_in changes outside v==001 have no effect.
- Arithmetic: unsigned only. The carry out of the 4-bit add is kept in sum[4] and shifted into P. Maximum result 15x15 = 225 (0xE1) with no overflow.

Test Plan:
1. clr=1 for 2 edges with random a_in, b_in and v -> product=0x00, done=0, busy=0, err=0.
2. a_in=3, b_in=5, legal sequence 000,001,...,110,000 -> product=0x0F. done is high for exactly 1 cycle, 5 edges after the load edge. busy is high for 5 cycles. err=0.
3. Back-to-back products 15x15 then 0x9, each with a legal sequence:
   - first run: product=0xE1;
   - second run: product=0x00;
   - product holds 0xE1 until the second done.
4. Change a_in/b_in every cycle during the steps of a 6x7 multiplication -> product=0x2A, using only the values present at load.
5. Drive v=111 after one clean multiplication, then drive the jump 010->100 in a separate run:
   - err=1 at the offending edge in each case;
   - err stays 1 through a later legal run;
   - err clears only on clr.
6. Assert clr while v==011 mid-multiplication, then run a legal 2x9 sequence:
   - all outputs are 0 the edge after clr;
   - the next result is product=0x12 with no residue from the aborted run.

Source files
------------

// File: rtl/mult4_datapath.sv
// Purpose : shift-add datapath for a 4x4 unsigned multiplier, steered by a 3-bit sequencer code.
// Latency : product/done update 5 edges after the load edge (one step per edge for four edges, then done).
// Backpressure: none; the upstream sequencer owns pacing and every code is acted on at each edge.
//
// Ports:
//   i_clk      system clock, rising edge
//   i_clr      synchronous active-high clear, overrides every other action
//   i_v        sequencer state code (000 idle, 001 load, 010..101 step, 110 done, 111 illegal)
//   i_a_in     multiplicand, captured only while i_v == 001
//   i_b_in     multiplier, captured only while i_v == 001
//   o_product  registered 2*WIDTH-bit result, held until the next done
//   o_done     registered pulse, high for each edge that saw i_v == 110
//   o_busy     registered, high while a multiplication is in flight
//   o_err      registered sticky flag for illegal codes or out-of-order transitions
module mult4_datapath #(
    parameter int WIDTH = 4
) (
    input  logic               i_clk,
    input  logic               i_clr,
    input  logic [2:0]         i_v,
    input  logic [WIDTH-1:0]   i_a_in,
    input  logic [WIDTH-1:0]   i_b_in,
    output logic [2*WIDTH-1:0] o_product,
    output logic               o_done,
    output logic               o_busy,
    output logic               o_err
);

    // The sequencer provides exactly four step codes, so only a 4-bit
    // operand width produces a complete product.
    if (WIDTH != 4) begin : g_width_chk
        $error("mult4_datapath: WIDTH must be 4");
    end

    localparam logic [2:0] V_IDLE  = 3'b000;
    localparam logic [2:0] V_LOAD  = 3'b001;
    localparam logic [2:0] V_STEP0 = 3'b010;
    localparam logic [2:0] V_STEP1 = 3'b011;
    localparam logic [2:0] V_STEP2 = 3'b100;
    localparam logic [2:0] V_STEP3 = 3'b101;
    localparam logic [2:0] V_DONE  = 3'b110;
    localparam logic [2:0] V_ILL   = 3'b111;

    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_p;
    logic [WIDTH-1:0]   r_q;
    logic [2:0]         r_prev;
    logic [2*WIDTH-1:0] r_product;
    logic               r_done;
    logic               r_busy;
    logic               r_err;

    logic [WIDTH:0]     w_addend;
    logic [WIDTH:0]     w_sum;
    logic               w_legal;

    // Partial product: add the multiplicand when the current multiplier LSB
    // is set. The carry lands in w_sum[WIDTH] and shifts into P's MSB.
    assign w_addend = r_q[0] ? {1'b0, r_a} : '0;
    assign w_sum    = {1'b0, r_p} + w_addend;

    // Only the forward walk of the sequencer, plus idle dwell, is legal.
    always_comb begin
        w_legal = 1'b0;
        case (r_prev)
            V_IDLE:  w_legal = (i_v == V_IDLE) || (i_v == V_LOAD);
            V_LOAD:  w_legal = (i_v == V_STEP0);
            V_STEP0: w_legal = (i_v == V_STEP1);
            V_STEP1: w_legal = (i_v == V_STEP2);
            V_STEP2: w_legal = (i_v == V_STEP3);
            V_STEP3: w_legal = (i_v == V_DONE);
            V_DONE:  w_legal = (i_v == V_IDLE);
            default: w_legal = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_a       <= '0;
            r_p       <= '0;
            r_q       <= '0;
            r_prev    <= V_IDLE;
            r_product <= '0;
            r_done    <= 1'b0;
            r_busy    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_prev <= i_v;
            r_done <= 1'b0;

            // Sticky: any out-of-order pair or the 111 code latches the
            // flag, while the action for the current code still happens.
            if (!w_legal || (i_v == V_ILL)) begin
                r_err <= 1'b1;
            end

            case (i_v)
                V_IDLE: begin
                    r_busy <= 1'b0;
                end
                V_LOAD: begin
                    r_a    <= i_a_in;
                    r_q    <= i_b_in;
                    r_p    <= '0;
                    r_busy <= 1'b1;
                end
                V_STEP0, V_STEP1, V_STEP2, V_STEP3: begin
                    r_p    <= w_sum[WIDTH:1];
                    r_q    <= {w_sum[0], r_q[WIDTH-1:1]};
                    r_busy <= 1'b1;
                end
                V_DONE: begin
                    r_product <= {r_p, r_q};
                    r_done    <= 1'b1;
                    r_busy    <= 1'b0;
                end
                default: begin
                    // 111: hold operands and product, drop busy.
                    r_busy <= 1'b0;
                end
            endcase
        end
    end

    assign o_product = r_product;
    assign o_done    = r_done;
    assign o_busy    = r_busy;
    assign o_err     = r_err;

endmodule
